// File: rtl/branch_pc_table.sv
// Fully associative PC tag table feeding the two-bit predictor indices.
// Define BPT_TARGET_STORE_EN to keep per-entry branch targets for redirect.
module branch_pc_table #(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             lookup_hit,
    output logic [PC_W-1:0]  lookup_target,
    output logic [IDX_W-1:0] pred_get_index,
    input  logic             resolve_valid,
    output logic             resolve_ready,
    input  logic [PC_W-1:0]  resolve_pc,
    input  logic             resolve_taken,
    input  logic [PC_W-1:0]  resolve_target,
    output logic             pred_set,
    output logic [IDX_W-1:0] pred_set_index,
    output logic             pred_feedback,
    output logic             pred_reset,
    output logic [IDX_W-1:0] pred_reset_index,
    input  logic             flush,
    output logic             busy
);
    localparam int RP_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [RP_W-1:0] LAST = RP_W'(ENTRIES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    logic [RP_W-1:0]   rp;
    logic [RP_W-1:0]   fc;
    logic [ENTRIES-1:0] valid;
    logic [PC_W-1:0]   tag [ENTRIES];

    logic              l_match;
    logic [RP_W-1:0]   l_idx;
    logic              r_hit;
    logic [RP_W-1:0]   r_idx;
    logic              vic_free;
    logic [RP_W-1:0]   vic;
    logic              accept;
    logic              alloc;

    always_comb begin
        l_match = 1'b0;
        l_idx   = '0;
        r_hit   = 1'b0;
        r_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == lookup_pc) begin
                l_match = 1'b1;
                l_idx   = RP_W'(i);
            end
            if (valid[i] && tag[i] == resolve_pc) begin
                r_hit = 1'b1;
                r_idx = RP_W'(i);
            end
        end
    end

    // Descending scan so the lowest-index free slot wins.
    always_comb begin
        vic_free = 1'b0;
        vic      = rp;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                vic_free = 1'b1;
                vic      = RP_W'(i);
            end
        end
    end

    assign resolve_ready  = (state == IDLE);
    assign busy           = (state == FLUSH);
    assign accept         = resolve_valid && resolve_ready && !flush;
    assign alloc          = accept && !r_hit && resolve_taken;
    assign lookup_hit     = l_match && (state == IDLE);
    assign pred_get_index = lookup_hit ? IDX_W'(l_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= FLUSH;
            valid            <= '0;
            rp               <= '0;
            fc               <= '0;
            pred_set         <= 1'b0;
            pred_set_index   <= '0;
            pred_feedback    <= 1'b0;
            pred_reset       <= 1'b0;
            pred_reset_index <= '0;
        end else begin
            pred_set   <= 1'b0;
            pred_reset <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                        fc    <= '0;
                        state <= FLUSH;
                    end else if (accept && r_hit) begin
                        pred_set       <= 1'b1;
                        pred_set_index <= IDX_W'(r_idx);
                        pred_feedback  <= resolve_taken;
                    end else if (alloc) begin
                        valid[vic]       <= 1'b1;
                        pred_reset       <= 1'b1;
                        pred_reset_index <= IDX_W'(vic);
                        if (!vic_free)
                            rp <= (rp == LAST) ? '0 : rp + 1'b1;
                    end
                end
                FLUSH: begin
                    pred_reset       <= 1'b1;
                    pred_reset_index <= IDX_W'(fc);
                    fc               <= fc + 1'b1;
                    if (fc == LAST) begin
                        fc    <= '0;
                        rp    <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc)
            tag[vic] <= resolve_pc;
    end

`ifdef BPT_TARGET_STORE_EN
    logic [PC_W-1:0] target [ENTRIES];

    always_ff @(posedge clk) begin
        if (alloc)
            target[vic] <= resolve_target;
        else if (accept && r_hit && resolve_taken)
            target[r_idx] <= resolve_target;
    end

    assign lookup_target = lookup_hit ? target[l_idx] : '0;
`else
    logic unused_target;
    assign unused_target = ^resolve_target;
    assign lookup_target = '0;
`endif

endmodule

// File: tb/tb_branch_pc_table.sv
// Directed bench for branch_pc_table: reset walk, resolve vectors,
// replacement, flush vs resolve priority.
module tb_branch_pc_table;
    localparam int ENTRIES = 64;
    localparam int PC_W    = 32;
    localparam int IDX_W   = 8;
`ifdef BPT_TARGET_STORE_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [PC_W-1:0]  lookup_pc;
    logic             lookup_hit;
    logic [PC_W-1:0]  lookup_target;
    logic [IDX_W-1:0] pred_get_index;
    logic             resolve_valid;
    logic             resolve_ready;
    logic [PC_W-1:0]  resolve_pc;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic             pred_set;
    logic [IDX_W-1:0] pred_set_index;
    logic             pred_feedback;
    logic             pred_reset;
    logic [IDX_W-1:0] pred_reset_index;
    logic             flush;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    branch_pc_table #(.ENTRIES(ENTRIES), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .lookup_pc(lookup_pc), .lookup_hit(lookup_hit),
        .lookup_target(lookup_target), .pred_get_index(pred_get_index),
        .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .pred_set(pred_set), .pred_set_index(pred_set_index),
        .pred_feedback(pred_feedback),
        .pred_reset(pred_reset), .pred_reset_index(pred_reset_index),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] lpc;
        logic        e_hit;
        logic [7:0]  e_gidx;
        logic [31:0] e_tgt;
        logic        e_set;
        logic [7:0]  e_sidx;
        logic        e_fb;
        logic        e_rst;
        logic [7:0]  e_ridx;
    } vec_t;

    // One transaction cycle, then strobe check on the following cycle.
    task automatic step(input vec_t v);
        @(negedge clk);
        resolve_valid  = v.rv;
        resolve_pc     = v.pc;
        resolve_taken  = v.tk;
        resolve_target = v.tgt;
        lookup_pc      = v.lpc;
        #1;
        check("lookup_hit", 64'(lookup_hit), 64'(v.e_hit));
        check("get_index", 64'(pred_get_index), 64'(v.e_gidx));
        check("lookup_target", 64'(lookup_target), TS ? 64'(v.e_tgt) : 64'd0);
        @(negedge clk);
        resolve_valid = 1'b0;
        #1;
        check("pred_set", 64'(pred_set), 64'(v.e_set));
        if (v.e_set) begin
            check("set_index", 64'(pred_set_index), 64'(v.e_sidx));
            check("feedback", 64'(pred_feedback), 64'(v.e_fb));
        end
        check("pred_reset", 64'(pred_reset), 64'(v.e_rst));
        if (v.e_rst)
            check("reset_index", 64'(pred_reset_index), 64'(v.e_ridx));
    endtask

    // Called #1 after the negedge of the first FLUSH cycle.
    task automatic check_walk();
        for (int k = 0; k <= ENTRIES; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            check("walk_busy", 64'(busy), 64'(k < ENTRIES));
            check("walk_ready", 64'(resolve_ready), 64'(k == ENTRIES));
            check("walk_pred_set", 64'(pred_set), 64'd0);
            check("walk_pred_reset", 64'(pred_reset), 64'(k > 0));
            if (k > 0)
                check("walk_index", 64'(pred_reset_index), 64'(k - 1));
        end
        @(negedge clk);
        #1;
        check("walk_end_reset", 64'(pred_reset), 64'd0);
    endtask

    vec_t vecs[7];
    vec_t v;

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        resolve_valid  = 1'b0;
        resolve_pc     = '0;
        resolve_taken  = 1'b0;
        resolve_target = '0;
        lookup_pc      = '0;

        //          rv  pc       tk  tgt      lpc      hit gidx tgt     set sidx fb rst ridx
        vecs[0] = '{1, 32'h100, 1, 32'h200, 32'h100, 0, 0, 32'h0,   0, 0, 0, 1, 0};
        vecs[1] = '{1, 32'h100, 0, 32'h0,   32'h100, 1, 0, 32'h200, 1, 0, 0, 0, 0};
        vecs[2] = '{1, 32'h300, 0, 32'h0,   32'h300, 0, 0, 32'h0,   0, 0, 0, 0, 0};
        vecs[3] = '{0, 32'h0,   0, 32'h0,   32'h300, 0, 0, 32'h0,   0, 0, 0, 0, 0};
        vecs[4] = '{1, 32'h100, 1, 32'h240, 32'h100, 1, 0, 32'h200, 1, 0, 1, 0, 0};
        vecs[5] = '{1, 32'h400, 1, 32'h500, 32'h100, 1, 0, 32'h240, 0, 0, 0, 1, 1};
        vecs[6] = '{0, 32'h0,   0, 32'h0,   32'h400, 1, 1, 32'h500, 0, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ready", 64'(resolve_ready), 64'd0);
        check("rst_pred_set", 64'(pred_set), 64'd0);
        check("rst_pred_reset", 64'(pred_reset), 64'd0);
        reset = 1'b0;
        check_walk();

        for (int i = 0; i < 7; i++)
            step(vecs[i]);

        // Fill remaining entries 2..63 with taken misses.
        for (int k = 2; k < ENTRIES; k++) begin
            v = '{1, 32'h1000 + 32'(k * 4), 1, 32'h2000, 32'h1000 + 32'(k * 4),
                  0, 0, 32'h0, 0, 0, 0, 1, 8'(k)};
            step(v);
        end
        step('{1, 32'h9000, 1, 32'h9100, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 0});
        step('{1, 32'h9004, 1, 32'h9200, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 1});
        step('{0, 32'h0, 0, 32'h0, 32'h100,  0, 0, 32'h0,    0, 0, 0, 0, 0});
        step('{0, 32'h0, 0, 32'h0, 32'h400,  0, 0, 32'h0,    0, 0, 0, 0, 0});
        step('{0, 32'h0, 0, 32'h0, 32'h9000, 1, 0, 32'h9100, 0, 0, 0, 0, 0});
        step('{0, 32'h0, 0, 32'h0, 32'h9004, 1, 1, 32'h9200, 0, 0, 0, 0, 0});
        step('{0, 32'h0, 0, 32'h0, 32'h1008, 1, 2, 32'h2000, 0, 0, 0, 0, 0});

        // Flush together with a resolve: resolve must be dropped.
        @(negedge clk);
        flush          = 1'b1;
        resolve_valid  = 1'b1;
        resolve_pc     = 32'hA000;
        resolve_taken  = 1'b1;
        resolve_target = 32'hB000;
        lookup_pc      = 32'h9000;
        #1;
        check("pre_flush_hit", 64'(lookup_hit), 64'd1);
        @(negedge clk);
        flush         = 1'b0;
        resolve_valid = 1'b0;
        #1;
        check("flush_hit_forced", 64'(lookup_hit), 64'd0);
        check_walk();
        step('{0, 32'h0, 0, 32'h0, 32'h9000, 0, 0, 32'h0, 0, 0, 0, 0, 0});
        step('{0, 32'h0, 0, 32'h0, 32'hA000, 0, 0, 32'h0, 0, 0, 0, 0, 0});
        step('{1, 32'hC000, 1, 32'hC100, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
